// File: rtl/ddr3_mem_pkg.sv
// Shared state and command encodings for the DDR3 command-port arbiter.
package ddr3_mem_pkg;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE    = 2'd0;
    localparam arb_state_t ISSUE   = 2'd1;
    localparam arb_state_t BURST   = 2'd2;
    localparam arb_state_t REFRESH = 2'd3;

    typedef logic [1:0] cmd_t;
    localparam cmd_t CMD_NOP     = 2'd0;
    localparam cmd_t CMD_WRITE   = 2'd1;
    localparam cmd_t CMD_READ    = 2'd2;
    localparam cmd_t CMD_REFRESH = 2'd3;

endpackage

// File: rtl/ddr3_refresh_timer.sv
// Free-running refresh interval timer; raises ref_pending every REFI_CYCLES
// cycles and holds it until the arbiter reports the refresh as accepted.
module ddr3_refresh_timer #(
    parameter int REFI_CYCLES = 7800
) (
    input  logic cpu_clk,
    input  logic RESET,
    input  logic ref_ack,
    output logic ref_pending
);
    import ddr3_mem_pkg::*;

    localparam int CNT_W = (REFI_CYCLES > 1) ? $clog2(REFI_CYCLES) : 1;

    logic [CNT_W-1:0] count;
    logic             expire;

    assign expire = (count == CNT_W'(REFI_CYCLES - 1));

    // An expiry while a refresh is already owed saturates rather than queueing.
    always_ff @(posedge cpu_clk) begin
        if (RESET) begin
            count       <= '0;
            ref_pending <= 1'b0;
        end else begin
            count <= expire ? '0 : count + CNT_W'(1);
            if (expire)
                ref_pending <= 1'b1;
            else if (ref_ack)
                ref_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/ddr3_mem_arbiter.sv
// Round-robin arbiter for the DDR3 controller command port: one burst per
// grant, with periodic refresh slotted in only between bursts.
module ddr3_mem_arbiter
    import ddr3_mem_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int BURST_BEATS = 16,
    parameter int REFI_CYCLES = 7800,
    parameter int RFC_CYCLES  = 110,
    parameter int ADDR_W      = 15,
    parameter int BA_W        = 3
) (
    input  logic                      cpu_clk,
    input  logic                      RESET,
    input  logic [NUM_REQ-1:0]        REQ,
    input  logic [NUM_REQ-1:0]        REQ_WR,
    input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
    input  logic [NUM_REQ*BA_W-1:0]   REQ_BA,
    output logic [NUM_REQ-1:0]        GNT,
    output logic [NUM_REQ-1:0]        DONE,
    input  logic                      CMD_RDY,
    input  logic                      BEAT_VALID,
    output logic                      ADDR_VALID,
    output logic                      WR_READY,
    output logic [1:0]                CMD,
    output logic [ADDR_W-1:0]         ADDR,
    output logic [BA_W-1:0]           BA,
    output logic                      REF_PENDING
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BEAT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam int RFC_W  = (RFC_CYCLES > 1) ? $clog2(RFC_CYCLES) : 1;

    arb_state_t          state;
    logic [IDX_W-1:0]    gnt_idx;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    next_ptr;
    logic [NUM_REQ-1:0]  gnt_onehot;
    logic [NUM_REQ-1:0]  done_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BA_W-1:0]     ba_q;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [RFC_W-1:0]    rfc_cnt;
    logic                rfc_wait;
    logic                ref_pending;
    logic                ref_ack;

    // First asserted request at or above ptr, wrapping around.
    function automatic logic [IDX_W-1:0] rr_select(input logic [NUM_REQ-1:0] req,
                                                   input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                sel   = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign sel_idx    = rr_select(REQ, rr_ptr);
    assign next_ptr   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    assign gnt_onehot = NUM_REQ'(1) << gnt_idx;
    assign ref_ack    = (state == REFRESH) && !rfc_wait && CMD_RDY;

    ddr3_refresh_timer #(
        .REFI_CYCLES (REFI_CYCLES)
    ) u_refresh_timer (
        .cpu_clk     (cpu_clk),
        .RESET       (RESET),
        .ref_ack     (ref_ack),
        .ref_pending (ref_pending)
    );

    // NOTE: state registers use non-blocking assignments only, so every branch
    // below sees the pre-edge values regardless of statement order.
    always_ff @(posedge cpu_clk) begin
        if (RESET) begin
            state    <= IDLE;
            gnt_idx  <= '0;
            rr_ptr   <= '0;
            done_q   <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            ba_q     <= '0;
            beat_cnt <= '0;
            rfc_cnt  <= '0;
            rfc_wait <= 1'b0;
        end else begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    if (CMD_RDY) begin
                        if (ref_pending) begin
                            state    <= REFRESH;
                            rfc_wait <= 1'b0;
                        end else if (|REQ) begin
                            state   <= ISSUE;
                            gnt_idx <= sel_idx;
                            wr_q    <= REQ_WR[sel_idx];
                            addr_q  <= REQ_ADDR[sel_idx*ADDR_W +: ADDR_W];
                            ba_q    <= REQ_BA[sel_idx*BA_W +: BA_W];
                        end
                    end
                end
                ISSUE: begin
                    if (CMD_RDY) begin
                        state    <= BURST;
                        beat_cnt <= '0;
                    end
                end
                BURST: begin
                    if (BEAT_VALID) begin
                        if (beat_cnt == BEAT_W'(BURST_BEATS - 1)) begin
                            state    <= IDLE;
                            beat_cnt <= '0;
                            done_q   <= gnt_onehot;
                            rr_ptr   <= next_ptr;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                REFRESH: begin
                    // Command phase until accepted, then a silent tRFC hold-off.
                    if (!rfc_wait) begin
                        if (CMD_RDY) begin
                            rfc_wait <= 1'b1;
                            rfc_cnt  <= '0;
                        end
                    end else if (rfc_cnt == RFC_W'(RFC_CYCLES - 1)) begin
                        state    <= IDLE;
                        rfc_wait <= 1'b0;
                    end else begin
                        rfc_cnt <= rfc_cnt + RFC_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        GNT        = '0;
        ADDR_VALID = 1'b0;
        WR_READY   = 1'b0;
        CMD        = CMD_NOP;
        case (state)
            ISSUE: begin
                GNT        = gnt_onehot;
                ADDR_VALID = 1'b1;
                WR_READY   = wr_q;
                CMD        = wr_q ? CMD_WRITE : CMD_READ;
            end
            BURST: begin
                GNT      = gnt_onehot;
                WR_READY = wr_q;
            end
            REFRESH: begin
                if (!rfc_wait) begin
                    ADDR_VALID = 1'b1;
                    CMD        = CMD_REFRESH;
                end
            end
            default: ;
        endcase
    end

    assign DONE        = done_q;
    assign ADDR        = addr_q;
    assign BA          = ba_q;
    assign REF_PENDING = ref_pending;

endmodule

// File: tb/tb_ddr3_mem_arbiter.sv
// Self-checking bench for ddr3_mem_arbiter: directed scenarios plus a random
// run compared against a transaction-level model of the arbitration rules.
module tb_ddr3_mem_arbiter;

    localparam int NUM_REQ     = 2;
    localparam int BURST_BEATS = 16;
    localparam int REFI_CYCLES = 40;
    localparam int RFC_CYCLES  = 6;
    localparam int ADDR_W      = 15;
    localparam int BA_W        = 3;
    localparam int VW          = 2 * NUM_REQ + 5;
    localparam int REF_OWNER   = NUM_REQ;

    logic                      cpu_clk = 1'b0;
    logic                      RESET;
    logic [NUM_REQ-1:0]        REQ;
    logic [NUM_REQ-1:0]        REQ_WR;
    logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR;
    logic [NUM_REQ*BA_W-1:0]   REQ_BA;
    logic [NUM_REQ-1:0]        GNT;
    logic [NUM_REQ-1:0]        DONE;
    logic                      CMD_RDY;
    logic                      BEAT_VALID;
    logic                      ADDR_VALID;
    logic                      WR_READY;
    logic [1:0]                CMD;
    logic [ADDR_W-1:0]         ADDR;
    logic [BA_W-1:0]           BA;
    logic                      REF_PENDING;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 cpu_clk = ~cpu_clk;

    ddr3_mem_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .BURST_BEATS (BURST_BEATS),
        .REFI_CYCLES (REFI_CYCLES),
        .RFC_CYCLES  (RFC_CYCLES),
        .ADDR_W      (ADDR_W),
        .BA_W        (BA_W)
    ) dut (
        .cpu_clk     (cpu_clk),
        .RESET       (RESET),
        .REQ         (REQ),
        .REQ_WR      (REQ_WR),
        .REQ_ADDR    (REQ_ADDR),
        .REQ_BA      (REQ_BA),
        .GNT         (GNT),
        .DONE        (DONE),
        .CMD_RDY     (CMD_RDY),
        .BEAT_VALID  (BEAT_VALID),
        .ADDR_VALID  (ADDR_VALID),
        .WR_READY    (WR_READY),
        .CMD         (CMD),
        .ADDR        (ADDR),
        .BA          (BA),
        .REF_PENDING (REF_PENDING)
    );

    // Reference model: who owns the port (-1 nobody, REF_OWNER = refresh),
    // whether its command is still outstanding, and progress counters.
    int                m_owner;
    bit                m_issuing;
    int                m_beats;
    int                m_rfc_left;
    int                m_next_rr;
    int                m_done_to;
    int                m_age;
    bit                m_owed;
    bit                m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [BA_W-1:0]   m_ba;

    task automatic model_reset();
        m_owner    = -1;
        m_issuing  = 1'b0;
        m_beats    = 0;
        m_rfc_left = 0;
        m_next_rr  = 0;
        m_done_to  = -1;
        m_age      = 0;
        m_owed     = 1'b0;
        m_wr       = 1'b0;
        m_addr     = '0;
        m_ba       = '0;
    endtask

    task automatic model_step();
        bit expire;
        bit ack;
        int r;
        if (RESET) begin
            model_reset();
            return;
        end
        expire    = (m_age == REFI_CYCLES - 1);
        ack       = (m_owner == REF_OWNER) && m_issuing && CMD_RDY;
        m_age     = expire ? 0 : m_age + 1;
        m_done_to = -1;
        if (m_owner < 0) begin
            if (CMD_RDY) begin
                if (m_owed) begin
                    m_owner   = REF_OWNER;
                    m_issuing = 1'b1;
                end else begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        r = (m_next_rr + k) % NUM_REQ;
                        if (m_owner < 0 && REQ[r]) begin
                            m_owner   = r;
                            m_issuing = 1'b1;
                            m_wr      = REQ_WR[r];
                            m_addr    = REQ_ADDR[r*ADDR_W +: ADDR_W];
                            m_ba      = REQ_BA[r*BA_W +: BA_W];
                        end
                    end
                end
            end
        end else if (m_owner == REF_OWNER) begin
            if (m_issuing) begin
                if (CMD_RDY) begin
                    m_issuing  = 1'b0;
                    m_rfc_left = RFC_CYCLES;
                end
            end else begin
                m_rfc_left--;
                if (m_rfc_left == 0) m_owner = -1;
            end
        end else begin
            if (m_issuing) begin
                if (CMD_RDY) begin
                    m_issuing = 1'b0;
                    m_beats   = 0;
                end
            end else if (BEAT_VALID) begin
                m_beats++;
                if (m_beats == BURST_BEATS) begin
                    m_done_to = m_owner;
                    m_next_rr = (m_owner + 1) % NUM_REQ;
                    m_owner   = -1;
                end
            end
        end
        if (expire)   m_owed = 1'b1;
        else if (ack) m_owed = 1'b0;
    endtask

    function automatic logic [VW-1:0] pack(input logic [NUM_REQ-1:0] g,
                                           input logic [NUM_REQ-1:0] d,
                                           input logic av, input logic wrr,
                                           input logic [1:0] c, input logic rp);
        return {g, d, av, wrr, c, rp};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return pack(GNT, DONE, ADDR_VALID, WR_READY, CMD, REF_PENDING);
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [NUM_REQ-1:0] g;
        logic [NUM_REQ-1:0] d;
        logic [1:0]         c;
        bit                 is_req;
        g      = '0;
        d      = '0;
        c      = 2'd0;
        is_req = (m_owner >= 0) && (m_owner < NUM_REQ);
        if (is_req) g[m_owner] = 1'b1;
        if (m_done_to >= 0) d[m_done_to] = 1'b1;
        if (m_issuing) c = (m_owner == REF_OWNER) ? 2'd3 : (m_wr ? 2'd1 : 2'd2);
        return pack(g, d, m_issuing, is_req && m_wr, c, m_owed);
    endfunction

    task automatic tick();
        model_step();
        @(posedge cpu_clk);
        @(negedge cpu_clk);
    endtask

    task automatic do_reset();
        RESET      = 1'b1;
        REQ        = '0;
        CMD_RDY    = 1'b0;
        BEAT_VALID = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET      = 1'b1;
        REQ        = '1;
        REQ_WR     = '1;
        REQ_ADDR   = (NUM_REQ*ADDR_W)'($urandom);
        REQ_BA     = (NUM_REQ*BA_W)'($urandom);
        CMD_RDY    = 1'b1;
        BEAT_VALID = 1'b1;
        tick();
        tick();
        n_checks++;
        if (dut_vec() !== '0 || ADDR !== '0 || BA !== '0)
            $display("FAIL reset_outputs: got vec=%h addr=%h ba=%h, expected all 0", dut_vec(), ADDR, BA);
        else n_pass++;
        RESET   = 1'b0;
        CMD_RDY = 1'b0;
        tick();
        n_checks++;
        if (dut_vec() !== '0)
            $display("FAIL reset_idle_no_rdy: got vec=%h, expected 0", dut_vec());
        else n_pass++;
    endtask

    task automatic test_single_write();
        do_reset();
        REQ                = 2'b01;
        REQ_WR             = 2'b01;
        REQ_ADDR[0 +: ADDR_W]      = 15'd32765;
        REQ_ADDR[ADDR_W +: ADDR_W] = 15'd1234;
        REQ_BA[0 +: BA_W]          = 3'd2;
        REQ_BA[BA_W +: BA_W]       = 3'd5;
        CMD_RDY            = 1'b1;
        tick();
        n_checks++;
        if (dut_vec() !== pack(2'b01, 2'b00, 1'b1, 1'b1, 2'd1, 1'b0) || ADDR !== 15'd32765 || BA !== 3'd2)
            $display("FAIL single_issue: got vec=%h addr=%0d ba=%0d, expected vec=%h addr=32765 ba=2",
                     dut_vec(), ADDR, BA, pack(2'b01, 2'b00, 1'b1, 1'b1, 2'd1, 1'b0));
        else n_pass++;
        REQ = '0;
        tick();
        BEAT_VALID = 1'b1;
        for (int b = 1; b <= BURST_BEATS; b++) begin
            tick();
            n_checks++;
            if (b < BURST_BEATS) begin
                if (dut_vec() !== pack(2'b01, 2'b00, 1'b0, 1'b1, 2'd0, 1'b0))
                    $display("FAIL single_burst beat %0d: got vec=%h, expected %h", b, dut_vec(),
                             pack(2'b01, 2'b00, 1'b0, 1'b1, 2'd0, 1'b0));
                else n_pass++;
            end else begin
                if (dut_vec() !== pack(2'b00, 2'b01, 1'b0, 1'b0, 2'd0, 1'b0))
                    $display("FAIL single_done: got vec=%h, expected %h", dut_vec(),
                             pack(2'b00, 2'b01, 1'b0, 1'b0, 2'd0, 1'b0));
                else n_pass++;
            end
        end
        BEAT_VALID = 1'b0;
        tick();
        n_checks++;
        if (dut_vec() !== '0)
            $display("FAIL single_done_once: got vec=%h, expected 0", dut_vec());
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int                 order[$];
        logic [NUM_REQ-1:0] prev_gnt;
        logic [NUM_REQ-1:0] last_gnt;
        int                 dones;
        int                 got;
        do_reset();
        REQ        = 2'b11;
        REQ_WR     = NUM_REQ'($urandom);
        CMD_RDY    = 1'b1;
        BEAT_VALID = 1'b1;
        prev_gnt   = '0;
        last_gnt   = '0;
        dones      = 0;
        for (int i = 0; i < 400 && dones < 4; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL rr_model cycle %0d: got %h, expected %h", i, dut_vec(), exp_vec());
            else n_pass++;
            if (GNT != '0 && prev_gnt == '0) begin
                order.push_back(GNT == 2'b01 ? 0 : (GNT == 2'b10 ? 1 : 99));
                last_gnt = GNT;
            end
            if (DONE != '0) begin
                dones++;
                n_checks++;
                if (DONE !== last_gnt || GNT !== '0)
                    $display("FAIL rr_done_owner: got done=%b gnt=%b, expected done=%b gnt=00", DONE, GNT, last_gnt);
                else n_pass++;
            end
            prev_gnt = GNT;
        end
        n_checks++;
        if (dones != 4) $display("FAIL rr_timeout: got %0d DONE pulses, expected 4", dones);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            got = (k < order.size()) ? order[k] : -1;
            n_checks++;
            if (got != k % 2) $display("FAIL rr_order grant %0d: got %0d, expected %0d", k, got, k % 2);
            else n_pass++;
        end
        REQ = '0;
    endtask

    task automatic test_refresh();
        bit rose;
        bit rose_in_grant;
        bit done_after;
        bit prev_p;
        int acc_at;
        int gap;
        do_reset();
        REQ           = 2'b01;
        REQ_WR        = 2'b00;
        CMD_RDY       = 1'b1;
        BEAT_VALID    = 1'b1;
        rose          = 1'b0;
        rose_in_grant = 1'b0;
        done_after    = 1'b0;
        prev_p        = 1'b0;
        acc_at        = -1;
        gap           = -1;
        for (int i = 1; i <= 200 && gap < 0; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL ref_model cycle %0d: got %h, expected %h", i, dut_vec(), exp_vec());
            else n_pass++;
            if (REF_PENDING && !prev_p && !rose) begin
                rose          = 1'b1;
                rose_in_grant = (GNT != '0);
            end
            if (DONE != '0 && rose) done_after = 1'b1;
            if (CMD == 2'd3 && acc_at < 0) begin
                n_checks++;
                if (!done_after || GNT !== '0)
                    $display("FAIL ref_order: got done_before=%0b gnt=%b, expected 1 and 00", done_after, GNT);
                else n_pass++;
                acc_at = i;
            end else if (acc_at >= 0 && i == acc_at + 1) begin
                n_checks++;
                if (REF_PENDING !== 1'b0 || ADDR_VALID !== 1'b0)
                    $display("FAIL ref_accept: got pending=%b av=%b, expected 0 0", REF_PENDING, ADDR_VALID);
                else n_pass++;
            end else if (acc_at >= 0 && GNT != '0) begin
                gap = i - acc_at;
            end
            prev_p = REF_PENDING;
        end
        n_checks++;
        if (!rose_in_grant) $display("FAIL ref_pending_mid_burst: got %0b, expected 1", rose_in_grant);
        else n_pass++;
        n_checks++;
        if (gap != RFC_CYCLES + 2) $display("FAIL ref_rfc_gap: got %0d, expected %0d", gap, RFC_CYCLES + 2);
        else n_pass++;
        REQ = '0;
    endtask

    task automatic test_refresh_tie();
        do_reset();
        REQ     = '0;
        REQ_WR  = 2'b01;
        CMD_RDY = 1'b1;
        for (int i = 1; i < REFI_CYCLES; i++) tick();
        REQ = 2'b01;
        tick();
        n_checks++;
        if (dut_vec() !== pack(2'b01, 2'b00, 1'b1, 1'b1, 2'd1, 1'b1))
            $display("FAIL tie_request_wins: got %h, expected %h", dut_vec(),
                     pack(2'b01, 2'b00, 1'b1, 1'b1, 2'd1, 1'b1));
        else n_pass++;
        REQ        = '0;
        BEAT_VALID = 1'b1;
        for (int i = 0; i <= BURST_BEATS; i++) tick();
        n_checks++;
        if (DONE !== 2'b01) $display("FAIL tie_done: got %b, expected 01", DONE);
        else n_pass++;
        tick();
        n_checks++;
        if (dut_vec() !== pack(2'b00, 2'b00, 1'b1, 1'b0, 2'd3, 1'b1))
            $display("FAIL tie_refresh_follows: got %h, expected %h", dut_vec(),
                     pack(2'b00, 2'b00, 1'b1, 1'b0, 2'd3, 1'b1));
        else n_pass++;
        BEAT_VALID = 1'b0;
    endtask

    task automatic test_cmd_rdy_stall();
        logic              wr;
        logic [ADDR_W-1:0] a;
        logic [BA_W-1:0]   ba;
        logic [1:0]        c;
        do_reset();
        wr       = 1'($urandom);
        a        = ADDR_W'($urandom);
        ba       = BA_W'($urandom);
        c        = wr ? 2'd1 : 2'd2;
        REQ      = 2'b01;
        REQ_WR   = {1'b0, wr};
        REQ_ADDR[0 +: ADDR_W] = a;
        REQ_BA[0 +: BA_W]     = ba;
        CMD_RDY  = 1'b1;
        tick();
        CMD_RDY    = 1'b0;
        REQ        = '0;
        REQ_ADDR   = ~REQ_ADDR;
        REQ_BA     = ~REQ_BA;
        BEAT_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== pack(2'b01, 2'b00, 1'b1, wr, c, 1'b0) || ADDR !== a || BA !== ba)
                $display("FAIL stall cycle %0d: got vec=%h addr=%h ba=%h, expected vec=%h addr=%h ba=%h",
                         i, dut_vec(), ADDR, BA, pack(2'b01, 2'b00, 1'b1, wr, c, 1'b0), a, ba);
            else n_pass++;
        end
        CMD_RDY = 1'b1;
        tick();
        n_checks++;
        if (dut_vec() !== pack(2'b01, 2'b00, 1'b0, wr, 2'd0, 1'b0))
            $display("FAIL stall_accept: got %h, expected %h", dut_vec(), pack(2'b01, 2'b00, 1'b0, wr, 2'd0, 1'b0));
        else n_pass++;
        for (int i = 0; i < BURST_BEATS - 1; i++) tick();
        n_checks++;
        if (GNT !== 2'b01 || DONE !== 2'b00)
            $display("FAIL stall_beat15: got gnt=%b done=%b, expected 01 00", GNT, DONE);
        else n_pass++;
        tick();
        n_checks++;
        if (DONE !== 2'b01 || GNT !== 2'b00)
            $display("FAIL stall_done: got gnt=%b done=%b, expected 00 01", GNT, DONE);
        else n_pass++;
        BEAT_VALID = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        REQ        = 2'b01;
        CMD_RDY    = 1'b1;
        BEAT_VALID = 1'b1;
        tick();
        REQ = '0;
        for (int i = 0; i <= BURST_BEATS; i++) tick();
        n_checks++;
        if (DONE !== 2'b01) $display("FAIL rst_first_done: got %b, expected 01", DONE);
        else n_pass++;
        REQ = 2'b11;
        tick();
        n_checks++;
        if (GNT !== 2'b10) $display("FAIL rst_second_grant: got %b, expected 10", GNT);
        else n_pass++;
        tick();
        for (int i = 0; i < 7; i++) tick();
        RESET = 1'b1;
        tick();
        n_checks++;
        if (dut_vec() !== '0 || ADDR !== '0 || BA !== '0)
            $display("FAIL rst_abort: got vec=%h addr=%h ba=%h, expected all 0", dut_vec(), ADDR, BA);
        else n_pass++;
        RESET = 1'b0;
        tick();
        n_checks++;
        if (GNT !== 2'b01) $display("FAIL rst_pointer: got %b, expected 01", GNT);
        else n_pass++;
        REQ = '0;
        tick();
        for (int i = 0; i < BURST_BEATS - 1; i++) tick();
        n_checks++;
        if (GNT !== 2'b01 || DONE !== 2'b00)
            $display("FAIL rst_beat_count: got gnt=%b done=%b, expected 01 00", GNT, DONE);
        else n_pass++;
        tick();
        n_checks++;
        if (DONE !== 2'b01) $display("FAIL rst_restart_done: got %b, expected 01", DONE);
        else n_pass++;
        BEAT_VALID = 1'b0;
    endtask

    task automatic test_beat_gaps();
        int  sent;
        bit  finished;
        do_reset();
        REQ     = '0;
        CMD_RDY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            BEAT_VALID = (i % 2 == 0);
            tick();
        end
        BEAT_VALID = 1'b0;
        REQ        = 2'b01;
        tick();
        REQ = '0;
        tick();
        sent     = 0;
        finished = 1'b0;
        for (int i = 0; i < 300 && !finished; i++) begin
            BEAT_VALID = ($urandom_range(0, 1) == 0);
            if (BEAT_VALID) sent++;
            tick();
            n_checks++;
            if (sent < BURST_BEATS) begin
                if (GNT !== 2'b01 || DONE !== 2'b00)
                    $display("FAIL gaps beat %0d: got gnt=%b done=%b, expected 01 00", sent, GNT, DONE);
                else n_pass++;
            end else begin
                finished = 1'b1;
                if (DONE !== 2'b01 || GNT !== 2'b00)
                    $display("FAIL gaps_done: got gnt=%b done=%b, expected 00 01", GNT, DONE);
                else n_pass++;
            end
        end
        n_checks++;
        if (!finished) $display("FAIL gaps_timeout: got %0d beats, expected %0d", sent, BURST_BEATS);
        else n_pass++;
        BEAT_VALID = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            RESET      = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 3) == 0) REQ = NUM_REQ'($urandom);
            REQ_WR     = NUM_REQ'($urandom);
            REQ_ADDR   = (NUM_REQ*ADDR_W)'($urandom);
            REQ_BA     = (NUM_REQ*BA_W)'($urandom);
            CMD_RDY    = ($urandom_range(0, 3) != 0);
            BEAT_VALID = ($urandom_range(0, 2) != 0);
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL random cycle %0d: got %h, expected %h", i, dut_vec(), exp_vec());
            else n_pass++;
            if (m_issuing && m_owner >= 0 && m_owner < NUM_REQ) begin
                n_checks++;
                if (ADDR !== m_addr || BA !== m_ba)
                    $display("FAIL random_addr cycle %0d: got %h/%h, expected %h/%h", i, ADDR, BA, m_addr, m_ba);
                else n_pass++;
            end
        end
        RESET = 1'b0;
    endtask

    initial begin
        RESET      = 1'b1;
        REQ        = '0;
        REQ_WR     = '0;
        REQ_ADDR   = '0;
        REQ_BA     = '0;
        CMD_RDY    = 1'b0;
        BEAT_VALID = 1'b0;
        model_reset();
        @(negedge cpu_clk);
        test_reset();
        test_single_write();
        test_round_robin();
        test_refresh();
        test_refresh_tie();
        test_cmd_rdy_stall();
        test_reset_mid_burst();
        test_beat_gaps();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
